// File: rtl/uart_tx_pkg.sv
// Shared constants and helpers for the 8N1 UART transmitter.
package uart_tx_pkg;

  localparam int DATA_BITS = 8;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: pulses tick on the last cycle of every div-cycle bit slot.
module uart_baud_tick #(
  parameter int div = 10
) (
  input  logic clk,
  input  logic resetn,
  input  logic restart,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = $clog2(div) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(div - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == CNT_LAST);

  // Reloading on tick keeps the counter inside 0..div-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per frame, start bit driven on the accepting edge.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int clk_freq_hz = 100_000_000,
  parameter int baud_rate   = 1_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_uart_tx
);

  localparam int DIV   = baud_div(clk_freq_hz, baud_rate);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(DATA_BITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } state_t;

  if (DIV < 2) begin : g_bad_div
    $fatal(1, "uart_tx: clk_freq_hz / baud_rate must be at least 2");
  end

  state_t               state;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 accept;
  logic                 tick;

  assign accept = (state == IDLE) && i_valid;

  uart_baud_tick #(
    .div(DIV)
  ) u_baud (
    .clk    (i_clk),
    .resetn (i_resetn),
    .restart(accept),
    .run    (state != IDLE),
    .tick   (tick)
  );

  // The line is updated on the same edge as the state change, so every
  // level lasts exactly one divider period and the line never glitches.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shift     <= '0;
      o_uart_tx <= 1'b1;
      o_ready   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            state     <= START;
            shift     <= i_data;
            o_uart_tx <= 1'b0;
            o_ready   <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state     <= DATA;
            bit_idx   <= '0;
            o_uart_tx <= shift[0];
            shift     <= shift >> 1;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == BIT_LAST) begin
              state     <= STOP;
              o_uart_tx <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              o_uart_tx <= shift[0];
              shift     <= shift >> 1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            state   <= IDLE;
            o_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at DIV=10 with a bit-centre sampling receiver.
module tb_uart_tx;

  localparam int CLK_HZ = 10_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int DIV    = 10;
  localparam int FRAME  = 10 * DIV;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic       valid  = 1'b0;
  logic [7:0] data   = 8'h00;
  logic       ready;
  logic       line;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] sb[$];

  // receiver state
  logic       rx_prev   = 1'b1;
  logic       rx_active = 1'b0;
  int         rx_cyc    = 0;
  logic [7:0] rx_byte   = 8'h00;
  logic [7:0] rx_exp    = 8'h00;

  uart_tx #(
    .clk_freq_hz(CLK_HZ),
    .baud_rate  (BAUD)
  ) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_data   (data),
    .i_valid  (valid),
    .o_ready  (ready),
    .o_uart_tx(line)
  );

  always #5 clk = ~clk;

  function automatic logic exp_line(input logic [7:0] b, input int j);
    if (j < DIV) return 1'b0;
    if (j < 9 * DIV) return b[j / DIV - 1];
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        rx_active = 1'b0;
      end else if (rx_active) begin
        rx_cyc++;
        if (rx_cyc == DIV / 2) begin
          tests++;
          if (line !== 1'b0) begin
            fails++;
            $display("FAIL rx_start_bit: line=%b required 0", line);
          end
        end else if (rx_cyc > DIV && rx_cyc < 9 * DIV && (rx_cyc % DIV) == DIV / 2) begin
          rx_byte[rx_cyc / DIV - 1] = line;
        end else if (rx_cyc == 9 * DIV + DIV / 2) begin
          tests++;
          if (line !== 1'b1) begin
            fails++;
            $display("FAIL rx_stop_bit: line=%b required 1", line);
          end
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL rx_unexpected_frame: got 0x%02h, no byte expected", rx_byte);
          end else begin
            rx_exp = sb.pop_front();
            if (rx_byte !== rx_exp) begin
              fails++;
              $display("FAIL rx_byte: got 0x%02h required 0x%02h", rx_byte, rx_exp);
            end
          end
          rx_active = 1'b0;
        end
      end else if (rx_prev === 1'b1 && line === 1'b0) begin
        rx_active = 1'b1;
        rx_cyc    = 0;
      end
      rx_prev = line;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (line !== 1'b1) begin
      fails++;
      $display("FAIL reset_line: line=%b required 1", line);
    end
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: ready=%b required 1", ready);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Request is driven right after reset release, so it lands on the first edge.
  task automatic test_single();
    data  = 8'h55;
    valid = 1'b1;
    sb.push_back(8'h55);
    @(posedge clk);
    #1;
    valid = 1'b0;
    for (int j = 0; j <= FRAME; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      tests++;
      if (line !== exp_line(8'h55, j)) begin
        fails++;
        $display("FAIL single_line[%0d]: line=%b required %b", j, line, exp_line(8'h55, j));
      end
      tests++;
      if (ready !== (j == FRAME)) begin
        fails++;
        $display("FAIL single_ready[%0d]: ready=%b required %b", j, ready, j == FRAME);
      end
    end
  endtask

  task automatic test_ignore();
    data  = 8'hA3;
    valid = 1'b1;
    sb.push_back(8'hA3);
    @(posedge clk);
    #1;
    valid = 1'b0;
    for (int j = 0; j <= FRAME + 15; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      if (j == 5) data = 8'hFF;
      if (j == 50) valid = 1'b1;
      if (j == 51) valid = 1'b0;
      tests++;
      if (line !== exp_line(8'hA3, j > FRAME ? FRAME : j)) begin
        fails++;
        $display("FAIL ignore_line[%0d]: line=%b required %b", j, line,
                 exp_line(8'hA3, j > FRAME ? FRAME : j));
      end
      tests++;
      if (ready !== (j >= FRAME)) begin
        fails++;
        $display("FAIL ignore_ready[%0d]: ready=%b required %b", j, ready, j >= FRAME);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    data  = 8'h00;
    valid = 1'b1;
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    @(posedge clk);
    #1;
    for (int j = 0; j <= 2 * FRAME + 1; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      if (j == 1) data = 8'hFF;
      if (j == FRAME + 1) valid = 1'b0;
      exp = (j <= FRAME) ? exp_line(8'h00, j) : exp_line(8'hFF, j - FRAME - 1);
      tests++;
      if (line !== exp) begin
        fails++;
        $display("FAIL b2b_line[%0d]: line=%b required %b", j, line, exp);
      end
      tests++;
      if (ready !== (j == FRAME || j == 2 * FRAME + 1)) begin
        fails++;
        $display("FAIL b2b_ready[%0d]: ready=%b required %b", j, ready,
                 j == FRAME || j == 2 * FRAME + 1);
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_reset_abort();
    data  = 8'h5A;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    for (int j = 0; j < 35; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      tests++;
      if (line !== exp_line(8'h5A, j)) begin
        fails++;
        $display("FAIL abort_pre_line[%0d]: line=%b required %b", j, line, exp_line(8'h5A, j));
      end
    end
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    tests++;
    if (line !== 1'b1) begin
      fails++;
      $display("FAIL abort_line_async: line=%b required 1", line);
    end
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_ready_async: ready=%b required 1", ready);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (line !== 1'b1 || ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_held: line=%b ready=%b required 1 1", line, ready);
    end
    resetn = 1'b1;
    data   = 8'h41;
    valid  = 1'b1;
    sb.push_back(8'h41);
    @(posedge clk);
    #1;
    valid = 1'b0;
    for (int j = 0; j <= FRAME; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      tests++;
      if (line !== exp_line(8'h41, j) || ready !== (j == FRAME)) begin
        fails++;
        $display("FAIL abort_post[%0d]: line=%b ready=%b required %b %b", j, line, ready,
                 exp_line(8'h41, j), j == FRAME);
      end
    end
  endtask

  task automatic test_random();
    int         w;
    logic [7:0] d;
    for (int n = 0; n < 200; n++) begin
      w = 0;
      while (ready !== 1'b1 && w < 300) begin
        @(posedge clk);
        #1;
        w++;
      end
      if (w >= 300) begin
        tests++;
        fails++;
        $display("FAIL random_ready_timeout: ready=%b required 1 within 300 cycles", ready);
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      d     = 8'($urandom);
      data  = d;
      valid = 1'b1;
      sb.push_back(d);
      @(posedge clk);
      #1;
      valid = 1'b0;
      data  = 8'($urandom);
    end
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL random_drain: %0d bytes outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random();
    repeat (20) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter clk_freq_hz, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter baud_rate, default 1_000_000, serial bit rate in bit/s.
REQ-003 i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 i_resetn  input  1  reset, asynchronous and active-low.
REQ-005 i_data  input  8  byte to transmit, sampled on acceptance.
REQ-006 i_valid  input  1  transmit request, one-cycle pulse or level.
REQ-007 o_ready  output  1  high = idle and able to accept a byte; low = busy sending.
REQ-008 o_uart_tx  output  1  serial line, idle high.

Function
REQ-009 DIV = clk_freq_hz / baud_rate, integer truncation. Each serial bit SHALL last exactly DIV clock cycles.
REQ-010 DIV < 2 SHALL be rejected at elaboration with a fatal error.
REQ-011 Frame format SHALL be 8N1: one start bit (0), data[0]..data[7] LSB first, one stop bit (1).
REQ-012 A byte SHALL be accepted at the rising edge where i_valid=1 and o_ready=1. Call this edge k.
REQ-013 i_data SHALL be latched into a shift register at edge k. Later changes to i_data SHALL NOT affect the frame in progress.
REQ-014 o_ready SHALL be driven low from edge k onward.
REQ-015 o_uart_tx SHALL be registered and SHALL go 0 at edge k.
REQ-016 Bit timing after edge k:
- data bit i (i = 0..7) starts at edge k+(i+1)*DIV;
- stop bit starts at edge k+9*DIV.
REQ-017 o_ready SHALL return high at edge k+10*DIV, with o_uart_tx=1.
REQ-018 Back-to-back frames: the earliest next acceptance SHALL be edge k+10*DIV+1, so the minimum frame period is 10*DIV+1 cycles. The line SHALL NOT glitch between frames.
REQ-019 i_valid while o_ready=0 SHALL be ignored: no queuing, no corruption of the current frame, no error flag.
REQ-020 State machine: IDLE -> START -> DATA (8 bits, bit counter 0..7) -> STOP -> IDLE. Transitions occur when the cycle counter reaches DIV-1, after which the counter reloads to 0.
REQ-021 Cycle counter width SHALL be $clog2(DIV)+1 bits. Counter and bit index SHALL never wrap out of range.
REQ-022 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-023 While i_resetn=0, and asynchronously on its assertion:
- state=IDLE, counters=0, shift register=0;
- o_uart_tx=1, o_ready=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame. The line SHALL return high immediately, with no partial stop bit.
REQ-025 The first acceptance after reset release SHALL be allowed at the first rising edge with i_resetn=1.

Structure
REQ-026 DIV and the state encoding SHALL be localparams inside uart_tx. No shared package is required.
REQ-027 An optional sub-module uart_baud_tick (counter producing a one-cycle tick every DIV cycles, restartable at acceptance) MAY hold the divider. Otherwise the design SHALL be one flat module.

Verification (clk_freq_hz=10_000_000, baud_rate=1_000_000, DIV=10)
REQ-028 Send 0x55 with i_valid pulsed at edge k:
- required line sequence, each level held exactly 10 cycles: 0,1,0,1,0,1,0,1,0,1;
- o_ready=0 for exactly cycles k..k+99, then high at edge k+100.
REQ-029 Send 0xA3, then change i_data to 0xFF at k+5 and pulse i_valid again at k+50 → the decoded byte SHALL be 0xA3, and the second request SHALL be ignored.
REQ-030 Hold i_valid=1 with i_data 0x00, then 0xFF → two frames, the second starting at edge k+101; line high during the gap cycle; decoded 0x00, then 0xFF.
REQ-031 Assert i_resetn=0 at k+35 (during data bit 2) → o_uart_tx=1 and o_ready=1 immediately. After release, 0x41 SHALL transmit correctly.
REQ-032 Random 200-byte stream with a bit-sampling receiver model (samples at bit centre, cycle 5 of each bit) → every byte matches; no framing error; stop bit always 1.
